// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;
  localparam int WAIT_W     = 4;

  // Word aligned and inside the attached memory; plain 32-bit compare, no wrap.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= mem_bytes - 32'd4);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bus of both pipeline ports plus the memory-side strobes.
interface mem_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic        gnt0;
  logic        ack0;
  logic [31:0] rdata0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        ack1;
  logic [31:0] rdata1;
  logic [1:0]  err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req0, addr0, req1, we1, addr1, wdata1, mem_rd,
    output gnt0, ack0, rdata0, gnt1, ack1, rdata1, err,
           mem_read, mem_write, mem_addr, mem_wd
  );

  modport master (
    output req0, addr0, req1, we1, addr1, wdata1, mem_rd,
    input  gnt0, ack0, rdata0, gnt1, ack1, rdata1, err,
           mem_read, mem_write, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; a tie goes to the port that did not win last.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_valid,
  output logic       o_winner
);

  logic r_last;

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = ~r_last;
      default: o_winner = 1'b0;
    endcase
  end

  // Reset value 1 makes port 0 win the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_update && o_valid) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between instruction fetch (port 0) and the MEM stage (port 1)
// with round-robin arbitration, wait states and alignment/range rejection.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  state_t              r_state, w_state_next;
  logic                r_port, w_port_next;
  logic [31:0]         r_addr, w_addr_next;
  logic                r_we, w_we_next;
  logic [31:0]         r_wdata, w_wdata_next;
  logic                r_err, w_err_next;
  logic [WAIT_W-1:0]   r_cnt, w_cnt_next;
  logic [31:0]         r_rdata0, w_rdata0_next;
  logic [31:0]         r_rdata1, w_rdata1_next;

  logic                w_valid;
  logic                w_winner;
  logic [31:0]         w_sel_addr;
  logic                w_mem_read;
  logic                w_mem_write;
  logic [31:0]         w_mem_addr;
  logic [31:0]         w_mem_wd;
  logic                w_busy;
  logic                w_resp;

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    ({bus.req1, bus.req0}),
    .i_update (r_state == ST_IDLE),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_sel_addr = w_winner ? bus.addr1 : bus.addr0;

  always_comb begin
    w_state_next  = r_state;
    w_port_next   = r_port;
    w_addr_next   = r_addr;
    w_we_next     = r_we;
    w_wdata_next  = r_wdata;
    w_err_next    = r_err;
    w_cnt_next    = r_cnt;
    w_rdata0_next = r_rdata0;
    w_rdata1_next = r_rdata1;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_addr    = 32'd0;
    w_mem_wd      = 32'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_port_next  = w_winner;
          w_addr_next  = w_sel_addr;
          w_we_next    = w_winner & bus.we1;
          w_wdata_next = w_winner ? bus.wdata1 : 32'd0;
          if (!addr_legal(w_sel_addr, 32'(MEM_BYTES))) begin
            w_err_next   = 1'b1;
            w_state_next = ST_RESP;
          end else begin
            w_err_next   = 1'b0;
            w_cnt_next   = WAIT_W'(WAIT_CYCLES);
            w_state_next = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        w_mem_read = ~r_we;
        w_mem_addr = r_addr;
        w_mem_wd   = r_wdata;
        // The write strobe only appears in the last cycle so the memory sees one write edge.
        if (r_cnt == '0) begin
          w_mem_write = r_we;
          if (!r_we) begin
            if (r_port) w_rdata1_next = bus.mem_rd;
            else        w_rdata0_next = bus.mem_rd;
          end
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      ST_RESP: w_state_next = ST_IDLE;

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_port   <= 1'b0;
      r_addr   <= 32'd0;
      r_we     <= 1'b0;
      r_wdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_state  <= w_state_next;
      r_port   <= w_port_next;
      r_addr   <= w_addr_next;
      r_we     <= w_we_next;
      r_wdata  <= w_wdata_next;
      r_err    <= w_err_next;
      r_cnt    <= w_cnt_next;
      r_rdata0 <= w_rdata0_next;
      r_rdata1 <= w_rdata1_next;
    end
  end

  // Grant/ack decode only from registered state, so they drop with reset immediately.
  assign w_busy = (r_state != ST_IDLE);
  assign w_resp = (r_state == ST_RESP);

  assign bus.gnt0      = w_busy & ~r_port;
  assign bus.gnt1      = w_busy &  r_port;
  assign bus.ack0      = w_resp & ~r_port;
  assign bus.ack1      = w_resp &  r_port;
  assign bus.err       = {w_resp & r_port & r_err, w_resp & ~r_port & r_err};
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wd    = w_mem_wd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with no wait states (A) and one with three (B), each with a word memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter_if ifa ();
  mem_arbiter_if ifb ();

  mem_arbiter #(.MEM_BYTES(1024), .WAIT_CYCLES(0)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  mem_arbiter #(.MEM_BYTES(1024), .WAIT_CYCLES(3)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;

  assign ifa.mem_rd = mem_a[ifa.mem_addr[9:2]];
  assign ifb.mem_rd = mem_b[ifb.mem_addr[9:2]];

  always @(posedge clk) begin
    if (ifa.mem_read) rd_a <= rd_a + 1;
    if (ifa.mem_write) begin
      mem_a[ifa.mem_addr[9:2]] <= ifa.mem_wd;
      wr_a <= wr_a + 1;
    end
    if (ifb.mem_read) rd_b <= rd_b + 1;
    if (ifb.mem_write) begin
      mem_b[ifb.mem_addr[9:2]] <= ifb.mem_wd;
      wr_b <= wr_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit use_b, input int p, input int max, output int n);
    logic got;
    n = 0;
    do begin
      tick();
      n++;
      got = use_b ? (p == 1 ? ifb.ack1 : ifb.ack0) : (p == 1 ? ifa.ack1 : ifa.ack0);
    end while (!got && n < max);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;
    logic [1:0] exp_ack;

    ifa.req0 = 0; ifa.addr0 = 0; ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = 0; ifa.wdata1 = 0;
    ifb.req0 = 0; ifb.addr0 = 0; ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = 0; ifb.wdata1 = 0;
    #2;
    check("reset_ctl_a", 32'({ifa.gnt0, ifa.gnt1, ifa.ack0, ifa.ack1, ifa.err, ifa.mem_read, ifa.mem_write}), 32'd0);
    check("reset_bus_a", ifa.mem_addr | ifa.mem_wd, 32'd0);
    check("reset_rdata_a", ifa.rdata0 | ifa.rdata1, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Seed word 8 through a store, then the plain load
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'd8; ifa.wdata1 = 32'h1122_3344;
    wait_ack(0, 1, 8, n);
    check("seed_store_lat", n, 2);
    ifa.req1 = 0; ifa.we1 = 0;
    tick();

    ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 32'd8;
    tick();
    check("load_gnt1", 32'(ifa.gnt1), 32'd1);
    check("load_memread", 32'({ifa.mem_read, ifa.mem_write}), 32'b10);
    check("load_memaddr", ifa.mem_addr, 32'd8);
    tick();
    check("load_ack1", 32'(ifa.ack1), 32'd1);
    check("load_err", 32'(ifa.err), 32'd0);
    check("load_rdata1", ifa.rdata1, 32'h1122_3344);
    ifa.req1 = 0;
    tick();
    check("load_idle", 32'({ifa.ack1, ifa.gnt1}), 32'd0);

    // Store then fetch the same word
    snap = wr_a;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'd16; ifa.wdata1 = 32'hDEAD_BEEF;
    wait_ack(0, 1, 8, n);
    check("store_lat", n, 2);
    check("store_err", 32'(ifa.err), 32'd0);
    ifa.req1 = 0; ifa.we1 = 0;
    tick();
    check("store_writes", wr_a - snap, 1);
    check("store_mem", mem_a[4], 32'hDEAD_BEEF);
    ifa.req0 = 1; ifa.addr0 = 32'd16;
    wait_ack(0, 0, 8, n);
    check("fetch_lat", n, 2);
    check("fetch_rdata0", ifa.rdata0, 32'hDEAD_BEEF);
    ifa.req0 = 0;
    tick();

    // Reset while a load is in ACCESS
    ifa.req1 = 1; ifa.addr1 = 32'd8;
    tick();
    check("rst_pre_gnt1", 32'(ifa.gnt1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", 32'({ifa.gnt1, ifa.mem_read, ifa.ack1}), 32'd0);
    check("rst_async_rdata", ifa.rdata0 | ifa.rdata1, 32'd0);
    ifa.req1 = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: strict alternation starting with port 0
    ifa.req0 = 1; ifa.addr0 = 32'd16; ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 32'd8;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(ifa.ack0 || ifa.ack1) && n < 10);
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("contend_ack_%0d", i), 32'({ifa.ack1, ifa.ack0}), 32'(exp_ack));
      check($sformatf("contend_lat_%0d", i), n, (i == 0) ? 2 : 3);
    end
    ifa.req0 = 0; ifa.req1 = 0;
    tick();

    // Rejected accesses
    snap = rd_a;
    ifa.req1 = 1; ifa.addr1 = 32'd6;
    wait_ack(0, 1, 8, n);
    check("err_misalign_lat", n, 1);
    check("err_misalign_err", 32'(ifa.err), 32'b10);
    ifa.req1 = 0;
    tick();
    check("err_misalign_nostrobe", rd_a - snap, 0);
    ifa.req0 = 1; ifa.addr0 = 32'd1024;
    wait_ack(0, 0, 8, n);
    check("err_range_lat", n, 1);
    check("err_range_err", 32'(ifa.err), 32'b01);
    check("err_range_rdata0", ifa.rdata0, 32'hDEAD_BEEF);
    ifa.req0 = 0;
    tick();

    // Last legal word
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'd1020; ifa.wdata1 = 32'hCAFE_F00D;
    wait_ack(0, 1, 8, n);
    check("last_store_lat", n, 2);
    ifa.req1 = 0; ifa.we1 = 0;
    tick();
    ifa.req1 = 1; ifa.addr1 = 32'd1020;
    wait_ack(0, 1, 8, n);
    check("last_load_err", 32'(ifa.err), 32'd0);
    check("last_load_rdata1", ifa.rdata1, 32'hCAFE_F00D);
    ifa.req1 = 0;
    tick();

    // Three wait states
    snap = wr_b;
    ifb.req1 = 1; ifb.we1 = 1; ifb.addr1 = 32'd32; ifb.wdata1 = 32'h1234_5678;
    wait_ack(1, 1, 20, n);
    check("ws_store_lat", n, 5);
    ifb.req1 = 0; ifb.we1 = 0;
    tick();
    check("ws_store_writes", wr_b - snap, 1);
    snap = rd_b;
    ifb.req1 = 1; ifb.addr1 = 32'd32;
    wait_ack(1, 1, 20, n);
    check("ws_load_lat", n, 5);
    check("ws_load_rdata1", ifb.rdata1, 32'h1234_5678);
    check("ws_load_reads", rd_b - snap, 4);
    ifb.req1 = 0;
    tick();

    // Reset during a store that has not reached its final cycle
    snap = wr_b;
    ifb.req1 = 1; ifb.we1 = 1; ifb.addr1 = 32'd32; ifb.wdata1 = 32'hFFFF_FFFF;
    tick(); tick();
    check("ws_rst_pre", 32'({ifb.gnt1, ifb.mem_write, ifb.mem_read}), 32'b100);
    rst_n = 1'b0;
    #1;
    check("ws_rst_strobe", 32'({ifb.gnt1, ifb.mem_write}), 32'd0);
    ifb.req1 = 0; ifb.we1 = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("ws_rst_mem", mem_b[8], 32'h1234_5678);
    check("ws_rst_writes", wr_b - snap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
